// File: rtl/conv_pkg.sv
// Shared types, mode constants and arithmetic helpers for the vertical K x 1
// convolution engine.
package conv_pkg;

  localparam logic PAD_OFF = 1'b0;
  localparam logic PAD_ON  = 1'b1;

  // Per-pixel markers carried alongside the data through the pipeline.
  typedef struct packed {
    logic sof;
    logic eol;
    logic last;
  } flags_t;

  // Accumulator width that can hold K signed products of an unsigned pixel
  // and a signed coefficient without overflow.
  function automatic int acc_w(input int dw, input int cw, input int k);
    return dw + cw + $clog2(k) + 1;
  endfunction

  // Round-half-up arithmetic right shift followed by a clamp to [0, 2^dw-1].
  function automatic logic [63:0] round_clamp(input logic signed [63:0] acc,
                                              input int unsigned       sh,
                                              input int                dw);
    logic signed [63:0] res;
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< dw) - 64'sd1;
    if (sh == 0) res = acc;
    else         res = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    if (res < 0)     return '0;
    if (res > max_v) return max_v;
    return res;
  endfunction

endpackage

// File: rtl/conv_vk_line_buf.sv
// Enable-gated delay line: dout is the sample written DEPTH enabled cycles ago.
module line_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 220
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // NOTE: start every always_comb with a full default so no path leaves a latch.
  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  // NOTE: storage is deliberately not reset; rows it has not filled yet are
  // masked downstream by the row counter.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_vk.sv
// Vertical K x 1 convolution on a raster pixel stream: line buffers, per-frame
// config latch, tap masking and a four-register arithmetic pipeline.
module conv_vk
  import conv_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int K     = 3,
  parameter int IMG_W = 220,
  parameter int IMG_H = 220,
  parameter int SW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   pxl_in,
  input  logic            in_valid,
  input  logic [K*CW-1:0] coef,
  input  logic [SW-1:0]   shift,
  input  logic            pad_en,
  output logic [DW-1:0]   pxl_out,
  output logic            out_valid,
  output logic            out_sof,
  output logic            out_eol,
  output logic            frame_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = DW + CW + 1;
  localparam int AW = acc_w(DW, CW, K);
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

  logic [XW-1:0]        col_q, col_d;
  logic [YW-1:0]        row_q, row_d;
  logic [K*CW-1:0]      coef_q, coef_d;
  logic [SW-1:0]        shift_q, shift_d;
  logic                 pad_q, pad_d;
  logic                 first_px, pad_eff;
  logic [K-1:0][DW-1:0] lb_tap;

  logic                 s1_valid_q, s1_valid_d;
  flags_t               s1_flags_q, s1_flags_d;
  logic [K-1:0][DW-1:0] s1_tap_q, s1_tap_d;

  logic                 s2_valid_q, s2_valid_d;
  flags_t               s2_flags_q, s2_flags_d;
  logic [SW-1:0]        s2_shift_q, s2_shift_d;
  logic signed [PW-1:0] s2_prod_q [K];
  logic signed [PW-1:0] s2_prod_d [K];

  logic                 s3_valid_q, s3_valid_d;
  flags_t               s3_flags_q, s3_flags_d;
  logic [SW-1:0]        s3_shift_q, s3_shift_d;
  logic signed [AW-1:0] s3_acc_q, s3_acc_d;

  logic [DW-1:0]        pxl_out_q, pxl_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sof_q, out_sof_d;
  logic                 out_eol_q, out_eol_d;
  logic                 out_last_q, out_last_d;
  logic                 frame_done_q, frame_done_d;

  // tap[0] is the live pixel; line buffer g delays tap[g-1] by one row.
  assign lb_tap[0] = pxl_in;
  for (genvar g = 1; g < K; g++) begin : g_lb
    line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb (
      .clk  (clk),
      .en   (in_valid),
      .din  (lb_tap[g-1]),
      .dout (lb_tap[g])
    );
  end

  // Pixel (0,0) sees its own config before the latch has captured it.
  assign first_px = in_valid && (col_q == '0) && (row_q == '0);
  assign pad_eff  = first_px ? pad_en : pad_q;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    coef_d  = coef_q;
    shift_d = shift_q;
    pad_d   = pad_q;
    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end
    if (first_px) begin
      coef_d  = coef;
      shift_d = shift;
      pad_d   = pad_en;
    end

    // S1: capture taps, zero rows above the frame, decide emission.
    s1_valid_d      = in_valid && (pad_eff == PAD_ON || int'(row_q) >= K - 1);
    s1_flags_d.sof  = (col_q == '0) &&
                      ((pad_eff == PAD_ON) ? (row_q == '0) : (int'(row_q) == K - 1));
    s1_flags_d.eol  = (col_q == COL_LAST);
    s1_flags_d.last = (col_q == COL_LAST) && (row_q == ROW_LAST);
    for (int k = 0; k < K; k++) s1_tap_d[k] = (int'(row_q) < k) ? '0 : lb_tap[k];

    // S2: products. coef_q already belongs to this pixel's frame here, while
    // shift must travel with the data because the next frame may relatch it.
    s2_valid_d = s1_valid_q;
    s2_flags_d = s1_flags_q;
    s2_shift_d = shift_q;
    s2_prod_d  = '{default: '0};
    for (int k = 0; k < K; k++)
      s2_prod_d[k] = PW'($signed(coef_q[k*CW +: CW])) * PW'($signed({1'b0, s1_tap_q[k]}));

    // S3: sum.
    s3_valid_d = s2_valid_q;
    s3_flags_d = s2_flags_q;
    s3_shift_d = s2_shift_q;
    s3_acc_d   = '0;
    for (int k = 0; k < K; k++) s3_acc_d = s3_acc_d + AW'(s2_prod_q[k]);

    // Output registers: round, shift and clamp.
    out_valid_d  = s3_valid_q;
    out_sof_d    = s3_valid_q && s3_flags_q.sof;
    out_eol_d    = s3_valid_q && s3_flags_q.eol;
    out_last_d   = s3_valid_q && s3_flags_q.last;
    pxl_out_d    = s3_valid_q ? DW'(round_clamp(64'(s3_acc_q), 32'(s3_shift_q), DW)) : pxl_out_q;
    frame_done_d = out_valid_q && out_last_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      coef_q       <= '0;
      shift_q      <= '0;
      pad_q        <= PAD_OFF;
      s1_valid_q   <= 1'b0;
      s1_flags_q   <= '0;
      s1_tap_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_flags_q   <= '0;
      s2_shift_q   <= '0;
      s2_prod_q    <= '{default: '0};
      s3_valid_q   <= 1'b0;
      s3_flags_q   <= '0;
      s3_shift_q   <= '0;
      s3_acc_q     <= '0;
      pxl_out_q    <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      coef_q       <= coef_d;
      shift_q      <= shift_d;
      pad_q        <= pad_d;
      s1_valid_q   <= s1_valid_d;
      s1_flags_q   <= s1_flags_d;
      s1_tap_q     <= s1_tap_d;
      s2_valid_q   <= s2_valid_d;
      s2_flags_q   <= s2_flags_d;
      s2_shift_q   <= s2_shift_d;
      s2_prod_q    <= s2_prod_d;
      s3_valid_q   <= s3_valid_d;
      s3_flags_q   <= s3_flags_d;
      s3_shift_q   <= s3_shift_d;
      s3_acc_q     <= s3_acc_d;
      pxl_out_q    <= pxl_out_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pxl_out    = pxl_out_q;
  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_vk.sv
// Scoreboard bench for conv_vk on a 4x4 image with a 3-tap kernel: stimulus
// pushes hand-computed expectations, a negedge monitor pops and compares them.
module tb_conv_vk;

  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int K     = 3;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int SW    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   pxl_in;
  logic            in_valid;
  logic [K*CW-1:0] coef;
  logic [SW-1:0]   shift;
  logic            pad_en;
  logic [DW-1:0]   pxl_out;
  logic            out_valid;
  logic            out_sof;
  logic            out_eol;
  logic            frame_done;

  typedef struct {
    logic [7:0] pxl;
    logic       sof;
    logic       eol;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   fd_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  conv_vk #(
    .DW(DW), .CW(CW), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .SW(SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pxl_in     (pxl_in),
    .in_valid   (in_valid),
    .coef       (coef),
    .shift      (shift),
    .pad_en     (pad_en),
    .pxl_out    (pxl_out),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Coefficients written as {tap2, tap1, tap0}.
  function automatic logic [23:0] pack3(input int c2, input int c1, input int c0);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic logic [31:0] rows4(input int r0, input int r1, input int r2, input int r3);
    return {8'(r3), 8'(r2), 8'(r1), 8'(r0)};
  endfunction

  // Every row is flat at rv[row]; ev[row] is the hand-computed output for it.
  // Config only holds its intended value on pixel (0,0); afterwards it is
  // scrambled to show the latch ignores mid-frame changes.
  task automatic drive_frame(input logic [31:0] rv, input logic [31:0] ev,
                             input logic [23:0] cf, input logic [23:0] cf_mid,
                             input logic [3:0] sh, input logic pd,
                             input int idle_pct, input int stop_after);
    int idx;
    idx = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (idx == stop_after) return;
        while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
          in_valid = 1'b0;
          pxl_in   = 8'($urandom);
          @(posedge clk); #1;
        end
        in_valid = 1'b1;
        pxl_in   = rv[r*8 +: 8];
        coef     = (idx == 0) ? cf : cf_mid;
        shift    = (idx == 0) ? sh : ~sh;
        pad_en   = (idx == 0) ? pd : ~pd;
        if (pd || r >= K - 1)
          exp_q.push_back('{pxl: ev[r*8 +: 8],
                            sof: (c == 0) && (pd ? (r == 0) : (r == K - 1)),
                            eol: (c == IMG_W - 1),
                            cyc: cyc + 4});
        if (r == IMG_H - 1 && c == IMG_W - 1) fd_q.push_back(cyc + 5);
        @(posedge clk); #1;
        idx++;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   fc;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("pxl_out", pxl_out, e.pxl);
        check("out_sof", out_sof, e.sof);
        check("out_eol", out_eol, e.eol);
        check("out_latency_cycle", cyc, e.cyc);
      end
    end
    if (frame_done) begin
      if (fd_q.size() == 0) begin
        check("spurious_frame_done", frame_done, 0);
      end else begin
        fc = fd_q.pop_front();
        check("frame_done_cycle", cyc, fc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 20000", cyc);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    pxl_in   = '0;
    coef     = '0;
    shift    = '0;
    pad_en   = 1'b0;
    #2;
    check("reset_pxl_out", pxl_out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sof", out_sof, 0);
    check("reset_out_eol", out_eol, 0);
    check("reset_frame_done", frame_done, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: smoothing, valid-only rows.
    drive_frame(rows4(100, 100, 100, 100), rows4(100, 100, 100, 100),
                pack3(1, 2, 1), pack3(0, 4, 0), 4'd2, 1'b0, 0, 16);
    // 2: zero-padded border, back-to-back with 1.
    drive_frame(rows4(100, 100, 100, 100), rows4(25, 75, 100, 100),
                pack3(1, 2, 1), pack3(0, 4, 0), 4'd2, 1'b1, 0, 16);
    // 3: negative result clamps to 0, then saturation to 255.
    drive_frame(rows4(10, 20, 30, 40), rows4(0, 0, 0, 0),
                pack3(1, 0, -1), pack3(4, 4, 4), 4'd0, 1'b0, 0, 16);
    drive_frame(rows4(255, 255, 255, 255), rows4(255, 255, 255, 255),
                pack3(4, 4, 4), pack3(1, 0, -1), 4'd0, 1'b0, 0, 16);
    // 4: scenario 1 with ~40% idle input cycles.
    drive_frame(rows4(100, 100, 100, 100), rows4(100, 100, 100, 100),
                pack3(1, 2, 1), pack3(0, 4, 0), 4'd2, 1'b0, 40, 16);
    idle(8);

    // 5: abort after pixel (1,2); the four results still in flight must vanish.
    drive_frame(rows4(100, 100, 100, 100), rows4(25, 75, 100, 100),
                pack3(1, 2, 1), pack3(0, 4, 0), 4'd2, 1'b1, 0, 7);
    reset    = 1'b1;
    in_valid = 1'b0;
    #2;
    check("abort_out_valid_async", out_valid, 0);
    repeat (4) @(posedge clk);
    check("abort_pending_results", exp_q.size(), 4);
    exp_q.delete();
    #1 reset = 1'b0;
    idle(4);
    drive_frame(rows4(100, 100, 100, 100), rows4(100, 100, 100, 100),
                pack3(1, 2, 1), pack3(0, 4, 0), 4'd2, 1'b0, 0, 16);

    // 6: back-to-back frames, coef moved to {0,4,0} mid-frame 1.
    drive_frame(rows4(100, 100, 100, 100), rows4(100, 100, 100, 100),
                pack3(1, 2, 1), pack3(0, 4, 0), 4'd2, 1'b0, 0, 16);
    drive_frame(rows4(100, 100, 100, 100), rows4(100, 100, 100, 100),
                pack3(0, 4, 0), pack3(1, 2, 1), 4'd2, 1'b0, 0, 16);
    in_valid = 1'b0;

    for (int i = 0; i < 40 && (exp_q.size() > 0 || fd_q.size() > 0); i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("outputs_drained", exp_q.size(), 0);
    check("frame_done_drained", fd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_vk.md
# conv_vk

Parametrised vertical K×1 convolution engine for raster-scan pixel streams. It generalises the fixed 3×1, 220-column convolution stage in several ways: run-time signed coefficients, a rounding right-shift, output clamping and an optional zero-padded border mode. It also accepts an input-valid qualifier that may have gaps. It sits between the pixel source and downstream filter stages, one pixel per accepted cycle.

## Interface
- DW, 8: pixel width (unsigned)
- CW, 8: coefficient width (signed, two's complement)
- K, 3: kernel height (taps); legal range 2..8
- IMG_W, 220: image width in pixels
- IMG_H, 220: image height in rows
- SW, 4: width of shift control
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears counters, pipeline valids and latched config
- pxl_in  in  DW  input pixel, raster order
- in_valid  in  1  pxl_in accepted on a rising edge where in_valid=1
- coef  in  K*CW  coef[k] in bits [k*CW +: CW]; applies to tap k
- shift  in  SW  arithmetic right shift applied to the sum
- pad_en  in  1  0 = valid-only mode, 1 = zero-pad mode
- pxl_out  out  DW  filtered pixel
- out_valid  out  1  pxl_out qualifier
- out_sof  out  1  with out_valid: first output of a frame
- out_eol  out  1  with out_valid: last output of a row
- frame_done  out  1  one-cycle pulse after last output of a frame

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accepted pixels. Col wraps to 0 and increments row. Row wraps to 0 after (IMG_H-1, IMG_W-1).
- Config latch: coef, shift and pad_en are sampled when pixel (0,0) is accepted. They are held for the whole frame. Changes mid-frame are ignored.
- Line buffers: K-1 cascaded delay lines of IMG_W entries, each advanced only on accepted pixels.
  - tap[0] = current pixel (row r, col c).
  - tap[k] = pixel at (r-k, c).
- Tap masking: if r < k, tap[k] is forced to 0. Buffer contents are never reset.
- Output emission per accepted pixel (r,c):
  - pad_en=0: emit only when r ≥ K-1, giving (IMG_H-K+1)·IMG_W outputs per frame.
  - pad_en=1: emit for every pixel, giving IMG_H·IMG_W outputs.
- Arithmetic:
  - acc = Σ signed(coef[k]) × {0,tap[k]}, width DW+CW+ceil(log2 K)+1, no overflow.
  - If shift>0, add round = 1<<(shift-1); res = (acc+round) >>> shift.
  - Clamp res to [0, 2^DW-1].
- out_sof marks the first emitted output of the frame:
  - pad_en=1: pixel (0,0).
  - pad_en=0: pixel (K-1,0).
- out_eol marks emitted outputs with c = IMG_W-1.
- frame_done pulses one cycle after the out_valid of pixel (IMG_H-1, IMG_W-1).
- Reset mid-frame: counters and pipeline valids are cleared immediately, and in-flight results are discarded. The next accepted pixel is treated as (0,0).

## Timing
- Pipeline is 3 stages:
  - S1: tap capture and mask.
  - S2: K products.
  - S3: sum, round, shift, clamp, output registers.
- Latency: an accepted pixel on edge n produces out_valid on edge n+3. The pipeline never stalls; in_valid gaps propagate as out_valid bubbles.
- Throughput: 1 pixel/cycle with in_valid held high. There is no backpressure input.
- Reset values: pxl_out=0, out_valid=0, out_sof=0, out_eol=0, frame_done=0, col=row=0, latched coef=0, shift=0, pad_en=0.
- Back-to-back frames: pixel (0,0) of frame N+1 may be accepted on the edge after (IMG_H-1, IMG_W-1) of frame N. The new config applies only to frame N+1 outputs. frame_done of N may coincide with pipeline activity for N+1.

## Structure
- Package conv_pkg holds:
  - accumulator-width function acc_w(DW,CW,K);
  - clamp/round function;
  - mode constants PAD_OFF/PAD_ON.
- Sub-module line_buf: a parametrised DW×IMG_W enable-gated delay line (shift register or RAM plus pointer), instantiated K-1 times in a generate loop.
- Counters, config latch, masking and the arithmetic pipeline live in conv_vk.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, K=3 unless noted.
1. coef={1,2,1}, shift=2, pad_en=0, constant 100, in_valid=1 → 8 outputs of 100. First out_valid with out_sof occurs 3 cycles after pixel (2,0) is accepted. out_eol on the 4th and 8th outputs. frame_done once.
2. Same as 1 with pad_en=1 → 16 outputs: row0 = 25, row1 = 75, rows 2-3 = 100.
3. coef={1,0,-1}, shift=0, rows valued 10,20,30,40 → all outputs clamp to 0. Then coef={4,4,4}, input 255 → all outputs 255 (saturation).
4. Scenario 1 with random in_valid gaps (~40% idle) → output value sequence identical to scenario 1. out_valid count 8, and each output appears exactly 3 cycles after its pixel.
5. Assert reset after pixel (1,2) is accepted → out_valid stays 0 with no late outputs. The following full frame matches scenario 1 exactly.
6. Two back-to-back frames; coef changed from {1,2,1} to {0,4,0} mid-frame 1 → frame 1 is all 100. Frame 2 with shift=2 is 100 from tap[1]. One frame_done per frame.
